// File: rtl/ysyx_25040111_rawsb.sv
// Read-after-write scoreboard between issue and execute: per-register pending-write
// counters gate the issue handshake until long-latency writers retire on any write-back channel.
module ysyx_25040111_rawsb #(
    parameter int unsigned NREG      = 16,
    parameter int unsigned CNT_W     = 2,
    parameter int unsigned NWB       = 2,
    parameter int unsigned ALLOW_WAW = 0,
    parameter int unsigned WB_BYPASS = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [4:0]        iss_rd,
    input  logic [4:0]        iss_rs1,
    input  logic [4:0]        iss_rs2,
    input  logic              iss_use1,
    input  logic              iss_use2,
    input  logic              iss_track,
    output logic              dn_valid,
    input  logic              dn_ready,
    input  logic [NWB-1:0]    wb_valid,
    input  logic [5*NWB-1:0]  wb_rd,
    output logic [NREG-1:0]   pend_mask,
    output logic              busy,
    output logic              err_uf,
    output logic              err_of
);

    localparam int unsigned IDX_W = $clog2(NREG);
    localparam int unsigned DEC_W = $clog2(NWB + 1);
    localparam int unsigned SUM_W = CNT_W + DEC_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_cnt [NREG];
    logic             r_err_uf;
    logic             r_err_of;

    logic [DEC_W-1:0] w_dec [NREG];
    logic [CNT_W-1:0] w_eff [NREG];
    logic [CNT_W-1:0] w_nxt [NREG];
    logic [SUM_W-1:0] w_sum [NREG];
    logic [NREG-1:0]  w_inc;
    logic             w_uf_any;
    logic             w_of_any;
    logic [IDX_W-1:0] w_rd_idx;
    logic [IDX_W-1:0] w_rs1_idx;
    logic [IDX_W-1:0] w_rs2_idx;
    logic             w_hazard;
    logic             w_fire;
    logic             w_unused;

    // Only the low index bits of each register address select a counter.
    assign w_rd_idx  = iss_rd[IDX_W-1:0];
    assign w_rs1_idx = iss_rs1[IDX_W-1:0];
    assign w_rs2_idx = iss_rs2[IDX_W-1:0];
    assign w_unused  = ^{iss_rd, iss_rs1, iss_rs2, wb_rd};

    // Per-register count of write-back channels retiring it this cycle; x0 never counts.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_dec[i] = '0;
            for (int k = 0; k < NWB; k++) begin
                if (i != 0 && wb_valid[k] && wb_rd[5*k +: IDX_W] == IDX_W'(i)) begin
                    w_dec[i] = w_dec[i] + DEC_W'(1);
                end
            end
        end
    end

    // Effective count seen by the hazard check, optionally net of same-cycle retirements.
    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_eff[i] = r_cnt[i];
            if (i == 0) begin
                w_eff[i] = '0;
            end else if (WB_BYPASS != 0) begin
                if (SUM_W'(w_dec[i]) >= SUM_W'(r_cnt[i])) begin
                    w_eff[i] = '0;
                end else begin
                    w_eff[i] = CNT_W'(SUM_W'(r_cnt[i]) - SUM_W'(w_dec[i]));
                end
            end
        end
    end

    assign w_hazard = (iss_use1 && w_eff[w_rs1_idx] != '0)
                   || (iss_use2 && w_eff[w_rs2_idx] != '0)
                   || (iss_track && ALLOW_WAW == 0 && w_eff[w_rd_idx] != '0)
                   || (iss_track && w_eff[w_rd_idx] == CNT_MAX);

    assign dn_valid  = iss_valid & ~w_hazard;
    assign iss_ready = dn_ready & ~w_hazard;
    assign w_fire    = iss_valid & iss_ready;

    // Next counter values with underflow floor and overflow saturation.
    always_comb begin
        w_uf_any = 1'b0;
        w_of_any = 1'b0;
        w_inc    = '0;
        for (int i = 0; i < NREG; i++) begin
            w_inc[i] = w_fire && iss_track && (w_rd_idx == IDX_W'(i)) && (i != 0);
            w_sum[i] = SUM_W'(r_cnt[i]) + SUM_W'(w_inc[i]);
            w_nxt[i] = '0;
            if (SUM_W'(w_dec[i]) > w_sum[i]) begin
                w_uf_any = 1'b1;
            end else if (w_sum[i] - SUM_W'(w_dec[i]) > SUM_W'(CNT_MAX)) begin
                w_nxt[i] = CNT_MAX;
                w_of_any = 1'b1;
            end else begin
                w_nxt[i] = CNT_W'(w_sum[i] - SUM_W'(w_dec[i]));
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= '0;
            end
            r_err_uf <= 1'b0;
            r_err_of <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_cnt[i] <= w_nxt[i];
            end
            r_err_uf <= r_err_uf | w_uf_any;
            r_err_of <= r_err_of | w_of_any;
        end
    end

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            pend_mask[i] = (r_cnt[i] != '0);
        end
    end

    assign busy   = |pend_mask;
    assign err_uf = r_err_uf;
    assign err_of = r_err_of;

endmodule

// File: tb/tb_ysyx_25040111_rawsb.sv
// Directed bench for the RAW scoreboard: a default instance driven from a vector table and a
// WAW-enabled, no-bypass instance driven by hand-written sequences.
module tb_ysyx_25040111_rawsb;

    logic clock;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instance A: defaults (ALLOW_WAW=0, WB_BYPASS=1)
    logic        a_reset, a_iss_valid, a_iss_ready, a_use1, a_use2, a_track, a_dn_valid, a_dn_ready;
    logic [4:0]  a_rd, a_rs1, a_rs2;
    logic [1:0]  a_wb_valid;
    logic [9:0]  a_wb_rd;
    logic [15:0] a_pend_mask;
    logic        a_busy, a_err_uf, a_err_of;

    ysyx_25040111_rawsb u_dut_a (
        .clock(clock), .reset(a_reset),
        .iss_valid(a_iss_valid), .iss_ready(a_iss_ready),
        .iss_rd(a_rd), .iss_rs1(a_rs1), .iss_rs2(a_rs2),
        .iss_use1(a_use1), .iss_use2(a_use2), .iss_track(a_track),
        .dn_valid(a_dn_valid), .dn_ready(a_dn_ready),
        .wb_valid(a_wb_valid), .wb_rd(a_wb_rd),
        .pend_mask(a_pend_mask), .busy(a_busy), .err_uf(a_err_uf), .err_of(a_err_of)
    );

    // Instance B: WAW pass-through, no bypass
    logic        b_reset, b_iss_valid, b_iss_ready, b_use1, b_use2, b_track, b_dn_valid, b_dn_ready;
    logic [4:0]  b_rd, b_rs1, b_rs2;
    logic [1:0]  b_wb_valid;
    logic [9:0]  b_wb_rd;
    logic [15:0] b_pend_mask;
    logic        b_busy, b_err_uf, b_err_of;

    ysyx_25040111_rawsb #(.NREG(16), .CNT_W(2), .NWB(2), .ALLOW_WAW(1), .WB_BYPASS(0)) u_dut_b (
        .clock(clock), .reset(b_reset),
        .iss_valid(b_iss_valid), .iss_ready(b_iss_ready),
        .iss_rd(b_rd), .iss_rs1(b_rs1), .iss_rs2(b_rs2),
        .iss_use1(b_use1), .iss_use2(b_use2), .iss_track(b_track),
        .dn_valid(b_dn_valid), .dn_ready(b_dn_ready),
        .wb_valid(b_wb_valid), .wb_rd(b_wb_rd),
        .pend_mask(b_pend_mask), .busy(b_busy), .err_uf(b_err_uf), .err_of(b_err_of)
    );

    typedef struct {
        logic        rst, iv;
        logic [4:0]  rd, rs1, rs2;
        logic        u1, u2, trk, dr;
        logic [1:0]  wbv;
        logic [4:0]  w0, w1;
        logic        dv, ir;
        logic [15:0] pm;
        logic        uf;
    } vec_t;

    localparam int NV = 23;
    vec_t tv [NV];

    int n_pass;
    int n_tot;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] rd,
                                input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic trk, input logic dr,
                                input logic [1:0] wbv, input logic [4:0] w0, input logic [4:0] w1,
                                input logic dv, input logic ir, input logic [15:0] pm,
                                input logic uf);
        vec_t v;
        v.rst = rst; v.iv = iv; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.u1 = u1; v.u2 = u2; v.trk = trk; v.dr = dr;
        v.wbv = wbv; v.w0 = w0; v.w1 = w1;
        v.dv = dv; v.ir = ir; v.pm = pm; v.uf = uf;
        return v;
    endfunction

    task automatic bstep(input logic iv, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic u1, input logic trk, input logic [1:0] wbv,
                         input logic [4:0] w0, input logic [4:0] w1);
        @(negedge clock);
        b_iss_valid = iv; b_rd = rd; b_rs1 = rs1; b_use1 = u1; b_track = trk;
        b_wb_valid = wbv; b_wb_rd = {w1, w0};
        #2;
    endtask

    initial begin
        n_pass = 0;
        n_tot  = 0;
        a_reset = 1'b1; a_iss_valid = 1'b0; a_rd = '0; a_rs1 = '0; a_rs2 = '0;
        a_use1 = 1'b0; a_use2 = 1'b0; a_track = 1'b0; a_dn_ready = 1'b1;
        a_wb_valid = '0; a_wb_rd = '0;
        b_reset = 1'b1; b_iss_valid = 1'b0; b_rd = '0; b_rs1 = '0; b_rs2 = '0;
        b_use1 = 1'b0; b_use2 = 1'b0; b_track = 1'b0; b_dn_ready = 1'b1;
        b_wb_valid = '0; b_wb_rd = '0;

        //            rst iv rd rs1 rs2 u1 u2 trk dr wbv w0 w1 | dv ir pm       uf
        tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0000, 0);
        tv[1]  = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0000, 0);
        tv[2]  = mk(0, 1, 0, 5, 0, 1, 0, 0, 1, 2'b00, 0, 0,   0, 0, 16'h0020, 0);
        tv[3]  = mk(0, 1, 0, 5, 0, 1, 0, 0, 1, 2'b01, 5, 0,   1, 1, 16'h0020, 0);
        tv[4]  = mk(0, 1, 5, 0, 5, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0000, 0);
        tv[5]  = mk(0, 1, 0, 0, 5, 0, 0, 0, 1, 2'b00, 0, 0,   1, 1, 16'h0020, 0);
        tv[6]  = mk(0, 1, 0, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0020, 0);
        tv[7]  = mk(0, 1, 5, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   0, 0, 16'h0020, 0);
        tv[8]  = mk(0, 1, 0, 6, 0, 1, 0, 0, 0, 2'b00, 0, 0,   1, 0, 16'h0020, 0);
        tv[9]  = mk(0, 1, 3, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0020, 0);
        tv[10] = mk(0, 1, 3, 0, 0, 0, 0, 1, 1, 2'b01, 3, 0,   1, 1, 16'h0028, 0);
        tv[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0, 9,   0, 1, 16'h0028, 0);
        tv[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0028, 1);
        tv[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 5, 3,   0, 1, 16'h0028, 1);
        tv[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0,   0, 1, 16'h0000, 1);
        tv[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0000, 1);
        tv[16] = mk(0, 1, 4, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0000, 1);
        tv[17] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0010, 1);
        tv[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0000, 0);
        tv[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 0, 0,   0, 1, 16'h0000, 0);
        tv[20] = mk(0, 1, 2, 0, 0, 0, 0, 1, 1, 2'b00, 0, 0,   1, 1, 16'h0000, 0);
        tv[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 2, 2,   0, 1, 16'h0004, 0);
        tv[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00, 0, 0,   0, 1, 16'h0000, 1);

        repeat (2) @(negedge clock);
        a_reset = 1'b0;
        b_reset = 1'b0;

        // Instance A: one table row per cycle, outputs sampled mid-low-phase
        for (int r = 0; r < NV; r++) begin
            @(negedge clock);
            a_reset = tv[r].rst; a_iss_valid = tv[r].iv; a_rd = tv[r].rd;
            a_rs1 = tv[r].rs1; a_rs2 = tv[r].rs2; a_use1 = tv[r].u1; a_use2 = tv[r].u2;
            a_track = tv[r].trk; a_dn_ready = tv[r].dr;
            a_wb_valid = tv[r].wbv; a_wb_rd = {tv[r].w1, tv[r].w0};
            #2;
            chk($sformatf("a_row%0d_dn_valid", r), 32'(a_dn_valid), 32'(tv[r].dv));
            chk($sformatf("a_row%0d_iss_ready", r), 32'(a_iss_ready), 32'(tv[r].ir));
            chk($sformatf("a_row%0d_pend_mask", r), 32'(a_pend_mask), 32'(tv[r].pm));
            chk($sformatf("a_row%0d_busy", r), 32'(a_busy), 32'(tv[r].pm != 16'h0000));
            chk($sformatf("a_row%0d_err_uf", r), 32'(a_err_uf), 32'(tv[r].uf));
            chk($sformatf("a_row%0d_err_of", r), 32'(a_err_of), 32'd0);
        end

        // Instance B: three tracked writes to x7 fill the counter, the fourth stalls
        for (int n = 0; n < 3; n++) begin
            bstep(1, 7, 0, 0, 1, 2'b00, 0, 0);
            chk($sformatf("b_waw%0d_dn_valid", n), 32'(b_dn_valid), 32'd1);
        end
        bstep(1, 7, 0, 0, 1, 2'b00, 0, 0);
        chk("b_full_dn_valid", 32'(b_dn_valid), 32'd0);
        chk("b_full_iss_ready", 32'(b_iss_ready), 32'd0);
        chk("b_full_pend_mask", 32'(b_pend_mask), 32'h80);
        // Both channels retire x7 together: 3 -> 1
        bstep(0, 0, 0, 0, 0, 2'b11, 7, 7);
        chk("b_dual_wb_pre_mask", 32'(b_pend_mask), 32'h80);
        bstep(0, 0, 0, 0, 0, 2'b01, 7, 0);
        chk("b_dual_wb_cnt1_mask", 32'(b_pend_mask), 32'h80);
        chk("b_err_of_clear", 32'(b_err_of), 32'd0);
        bstep(0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("b_drained_mask", 32'(b_pend_mask), 32'h0);
        chk("b_drained_uf", 32'(b_err_uf), 32'd0);

        // Without bypass, a same-cycle write-back releases the consumer one cycle later
        bstep(1, 5, 0, 0, 1, 2'b00, 0, 0);
        chk("b_ld5_fire", 32'(b_dn_valid), 32'd1);
        bstep(1, 0, 5, 1, 0, 2'b01, 5, 0);
        chk("b_nobyp_dn_valid", 32'(b_dn_valid), 32'd0);
        chk("b_nobyp_iss_ready", 32'(b_iss_ready), 32'd0);
        bstep(1, 0, 5, 1, 0, 2'b00, 0, 0);
        chk("b_nobyp_next_dn_valid", 32'(b_dn_valid), 32'd1);
        chk("b_nobyp_next_mask", 32'(b_pend_mask), 32'h0);

        // Reset with two writes to x4 outstanding discards them
        bstep(1, 4, 0, 0, 1, 2'b00, 0, 0);
        bstep(1, 4, 0, 0, 1, 2'b00, 0, 0);
        @(negedge clock);
        b_iss_valid = 1'b0; b_track = 1'b0; b_use1 = 1'b0; b_reset = 1'b1;
        #2;
        chk("b_midflight_mask", 32'(b_pend_mask), 32'h10);
        @(negedge clock);
        b_reset = 1'b0;
        #2;
        chk("b_post_reset_mask", 32'(b_pend_mask), 32'h0);
        chk("b_post_reset_busy", 32'(b_busy), 32'd0);
        chk("b_post_reset_uf", 32'(b_err_uf), 32'd0);
        chk("b_post_reset_of", 32'(b_err_of), 32'd0);
        // A late write-back for the discarded x4 now underflows
        bstep(0, 0, 0, 0, 0, 2'b01, 4, 0);
        bstep(0, 0, 0, 0, 0, 2'b00, 0, 0);
        chk("b_late_wb_uf", 32'(b_err_uf), 32'd1);
        chk("b_late_wb_mask", 32'(b_pend_mask), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_rawsb.md
Name: ysyx_25040111_rawsb

Overview:
- Parametrised read-after-write scoreboard placed between IDU issue and EXU accept.
- Replaces the fixed 16-bit single-bit lock vector with per-register pending-write counters, a configurable register count and N write-back clear channels.
- Adds optional WAW pass-through and same-cycle write-back bypass.
- Gates the issue handshake. Tracks long-latency writers, e.g. loads, until their write-back retires.

Parameters:
- NREG, 16: architectural registers tracked; 16 (RV32E) or 32. Index = low log2(NREG) bits of the address.
- CNT_W, 2: pending counter width; max outstanding writes per register = 2^CNT_W-1.
- NWB, 2: number of independent write-back clear channels.
- ALLOW_WAW, 0: 0 = a pending rd stalls a new tracked write to the same rd; 1 = the counter increments instead.
- WB_BYPASS, 1: 1 = a same-cycle write-back that drains a counter to 0 clears the hazard combinationally.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- iss_valid  in  1  upstream instruction valid.
- iss_ready  out  1  scoreboard accepts the instruction.
- iss_rd  in  5  destination register.
- iss_rs1  in  5  source register 1.
- iss_rs2  in  5  source register 2.
- iss_use1  in  1  rs1 actually read.
- iss_use2  in  1  rs2 actually read.
- iss_track  in  1  instruction writes rd with long latency; set a pending count.
- dn_valid  out  1  forwarded valid to EXU.
- dn_ready  in  1  EXU ready.
- wb_valid  in  NWB  per-channel write-back retire strobe.
- wb_rd  in  5*NWB  per-channel retired rd; channel k = bits [5k+4:5k].
- pend_mask  out  NREG  bit i = counter i nonzero.
- busy  out  1  |pend_mask.
- err_uf  out  1  sticky: write-back hit a zero counter.
- err_of  out  1  sticky: increment attempted at max count.

Behaviour:
- Reset (synchronous, active-high):
  - all counters 0; err_uf=0; err_of=0.
  - Consequently pend_mask=0 and busy=0.
  - Reset mid-flight discards all pending state; late write-backs then set err_uf.
- Register 0:
  - never incremented, never causes a hazard.
  - Write-backs to it are ignored and do not set err_uf.
- Effective count eff[i]:
  - WB_BYPASS=1: cnt[i] minus the number of wb channels hitting i this cycle, floored at 0.
  - WB_BYPASS=0: cnt[i].
- hazard is asserted when any of these holds:
  - iss_use1 and eff[rs1]!=0
  - iss_use2 and eff[rs2]!=0
  - iss_track and ALLOW_WAW=0 and eff[rd]!=0
  - iss_track and eff[rd]==max: full counter, stall, no overflow.
- Handshake (all combinational, no added latency):
  - dn_valid = iss_valid & ~hazard
  - iss_ready = dn_ready & ~hazard
  - fire = iss_valid & iss_ready
- Counter update per cycle, for each i:
  - next = cnt[i] + inc - dec.
  - inc = fire & iss_track & (rd==i) & (i!=0).
  - dec = number of wb channels with wb_valid & wb_rd==i.
- Simultaneous events:
  - Increment and decrement on the same register in one cycle net out.
  - Two channels hitting the same register decrement by 2.
- Underflow: if dec > cnt[i]+inc, the counter saturates at 0 and err_uf sets.
- Overflow: err_of sets only if inc is applied at max. The hazard rule prevents this, so err_of asserting indicates an RTL bug.
- pend_mask, busy and errors derive from the registered counters, i.e. they are visible the cycle after the update.
- Single always block for counters; no latches; outputs glitch-tolerant (combinational handshake path only).

Test Plan:
- Reset, then NREG=16, issue load rd=5 track=1 with dn_ready=1 -> fire in cycle 0; pend_mask=0x0020 at cycle 1; busy=1.
- Issue rs1=5 use1=1 while cnt[5]=1 -> dn_valid=0, iss_ready=0. Pulse wb_valid[0] wb_rd=5:
  - WB_BYPASS=1 -> dn_valid=1 in the same cycle.
  - WB_BYPASS=0 -> dn_valid=1 one cycle later.
- iss_rs2=5 with use2=0 while cnt[5]=1 -> no stall, dn_valid=1. Track rd=0 -> pend_mask stays 0.
- ALLOW_WAW=1, CNT_W=2: three tracked issues to rd=7 -> cnt=3; fourth stalls; err_of stays 0. Two channels retire rd=7 together -> cnt=1.
- Same cycle: tracked issue rd=3 (cnt 1) plus wb rd=3 -> cnt remains 1. wb rd=9 when cnt=0 -> err_uf=1 sticky until reset; cnt stays 0.
- Reset asserted with cnt[4]=2 mid-flight -> next cycle pend_mask=0, busy=0, err flags 0.
